// File: rtl/proj_scan_pkg.sv
// Shared types and constants for the projection truth-table scanner.
package proj_scan_pkg;

    localparam int NUM_INPUTS_DEF = 14;
    localparam int WORD_W_DEF     = 32;

    // CRC-32 polynomial used by the optional output-word signature.
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int words_per_scan(input int num_inputs, input int word_w);
        return (1 << num_inputs) / word_w;
    endfunction

endpackage

// File: rtl/proj_scan_packer.sv
// Truth-table word packer: bit accumulator, output word register and
// valid/ready handling including the word-completion stall.
module proj_scan_packer
    import proj_scan_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      sample_en,
    input  logic [$clog2(WORD_W)-1:0] bit_idx,
    input  logic                      y,
    input  logic                      out_ready,
    output logic                      advance,
    output logic                      handshake,
    output logic [WORD_W-1:0]         out_data,
    output logic                      out_valid
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] word_now;
    logic              last_bit;
    logic              load;

    always_comb begin
        last_bit  = (bit_idx == LAST_IDX);
        handshake = valid_q && out_ready;
        // A completing word may only land if the register is free or being emptied now.
        advance   = sample_en && !(last_bit && valid_q && !out_ready);
        load      = advance && last_bit;

        word_now          = acc_q;
        word_now[bit_idx] = y;

        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (clear) begin
            acc_d = '0;
        end else if (advance) begin
            acc_d = word_now;
        end

        if (load) begin
            data_d  = word_now;
            valid_d = 1'b1;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/projection_truth_scanner.sv
// Exhaustive stimulus/capture stage for a single-output projection block.
// Optional PROJ_SCANNER_SIGNATURE_EN adds a 32-bit MISR over emitted words.
module projection_truth_scanner
    import proj_scan_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int WORD_W     = WORD_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [NUM_INPUTS-1:0] x_o,
    input  logic                  y_i,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_INPUTS:0]   ones_count
`ifdef PROJ_SCANNER_SIGNATURE_EN
    ,
    output logic [31:0]           signature
`endif
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [NUM_INPUTS-1:0] PAT_ONE = NUM_INPUTS'(1);

    state_e                state_q, state_d;
    logic [NUM_INPUTS-1:0] pattern_q, pattern_d;
    logic [NUM_INPUTS:0]   ones_q, ones_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  clear;
    logic                  sample_en;
    logic                  advance;
    logic                  handshake;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        ones_d    = ones_q;
        clear     = 1'b0;
        sample_en = (state_q == ST_SCAN);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    pattern_d = '0;
                    ones_d    = '0;
                    clear     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (advance) begin
                    ones_d = ones_q + {{NUM_INPUTS{1'b0}}, y_i};
                    // The all-ones pattern is the last one; its word has just been loaded.
                    if (&pattern_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        pattern_d = pattern_q + PAT_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (handshake) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            ones_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            ones_q    <= ones_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    proj_scan_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .sample_en (sample_en),
        .bit_idx   (pattern_q[IDX_W-1:0]),
        .y         (y_i),
        .out_ready (out_ready),
        .advance   (advance),
        .handshake (handshake),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    assign x_o        = pattern_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;

`ifdef PROJ_SCANNER_SIGNATURE_EN
    logic [31:0] sig_q, sig_d;

    // Shift with CRC feedback, then fold the word in 32-bit slices.
    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [WORD_W-1:0] d);
        logic [31:0] r;
        r = {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0);
        for (int i = 0; i < WORD_W; i++) begin
            r[i % 32] = r[i % 32] ^ d[i];
        end
        return r;
    endfunction

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (handshake) begin
            sig_d = misr_step(sig_q, out_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`endif

endmodule

// File: tb/tb_projection_truth_scanner.sv
// Scoreboard bench for projection_truth_scanner with behavioural projection stubs.
module tb_projection_truth_scanner;
    import proj_scan_pkg::*;

    localparam int NI = 14;
    localparam int WW = 32;
    localparam int NPAT = 1 << NI;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NI-1:0] x_o;
    logic          y_i;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [NI:0]   ones_count;
`ifdef PROJ_SCANNER_SIGNATURE_EN
    logic [31:0]   signature;
`endif

    int            mode = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [WW-1:0] exp_q[$];
    int            words_seen;
    int            done_seen;
    int            cyc = 0;
    int            last_hs_cyc;
    int            done_cyc;
    bit            prev_stall = 1'b0;
    logic [WW-1:0] prev_data;
    logic [31:0]   sig_model;

    always #5 clk = ~clk;

    function automatic bit model(input int m, input int p);
        case (m)
            0:       return p[0];
            1:       return (p == NPAT - 1);
            default: return (^(p & 32'h2B5D)) ^ (p[3] & p[9]);
        endcase
    endfunction

    assign y_i = model(mode, int'(x_o));

    projection_truth_scanner #(
        .NUM_INPUTS (NI),
        .WORD_W     (WW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_o        (x_o),
        .y_i        (y_i),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count)
`ifdef PROJ_SCANNER_SIGNATURE_EN
        ,
        .signature  (signature)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Called once per negedge while a scan is in flight.
    task automatic sample();
        logic [WW-1:0] e;
        if (prev_stall) begin
            check("hold_data", 64'(out_data), 64'(prev_data));
            check("hold_valid", 64'(out_valid), 64'd1);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("word", 64'(out_data), 64'(e));
            end
            sig_model = (sig_model << 1) ^ (sig_model[31] ? 32'h04C11DB7 : 32'h0) ^ out_data;
            words_seen++;
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        cyc++;
    endtask

    // pol: 0 = always ready, 1 = ready low for 80 cycles, 2 = random ready
    task automatic run_scan(input int m, input int pol, input bit poke);
        logic [WW-1:0] w;
        int            ones;
        mode = m;
        exp_q.delete();
        ones = 0;
        w    = '0;
        for (int p = 0; p < NPAT; p++) begin
            bit b;
            b = model(m, p);
            ones += int'(b);
            w[p % WW] = b;
            if (p % WW == WW - 1) exp_q.push_back(w);
        end
        words_seen = 0;
        done_seen  = 0;
        sig_model  = '0;
        prev_stall = 1'b0;

        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = (pol != 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
        check("x_start", 64'(x_o), 64'd0);
        @(negedge clk);
        sample();

        for (int c = 0; c < 30000 && done_seen == 0; c++) begin
            @(posedge clk); #1;
            if (pol == 1) out_ready = (c >= 80);
            else if (pol == 2) out_ready = 1'($urandom_range(0, 1));
            start = poke && (c == 300);
            @(negedge clk);
            if (pol == 1 && c == 79) begin
                check("stall_x", 64'(x_o), 64'd63);
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_word", 64'(out_data), 64'hAAAAAAAA);
            end
            sample();
        end

        check("done_seen", 64'(done_seen), 64'd1);
        check("done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
        check("busy_in_done", 64'(busy), 64'd1);
        check("word_count", 64'(words_seen), 64'(words_per_scan(NI, WW)));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("ones_count", 64'(ones_count), 64'(ones));
`ifdef PROJ_SCANNER_SIGNATURE_EN
        check("signature", 64'(signature), 64'(sig_model));
`endif
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("busy_fall", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("ones_hold", 64'(ones_count), 64'(ones));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 64'(x_o), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ones", 64'(ones_count), 64'd0);
        rst_n = 1'b1;

        run_scan(0, 0, 1'b0);
        run_scan(1, 0, 1'b0);
        run_scan(0, 1, 1'b0);
        run_scan(2, 2, 1'b1);

        // Abort a scan part-way through with an asynchronous reset.
        mode = 0;
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 2000 && x_o != NI'(1000); c++) @(negedge clk);
        check("reach_1000", 64'(x_o), 64'd1000);
        rst_n = 1'b0;
        #1;
        check("abort_x", 64'(x_o), 64'd0);
        check("abort_data", 64'(out_data), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ones", 64'(ones_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_abort", 64'(busy), 64'd0);
        check("x_after_abort", 64'(x_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
